// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: macro command struct, idle command
// and the bit-mask to byte-mask conversion.
package sram_arb_pkg;

    localparam int unsigned SRAM_AW = 12;
    localparam int unsigned SRAM_DW = 32;
    localparam int unsigned SRAM_BW = SRAM_DW / 8;

    typedef struct packed {
        logic               csb;
        logic               web;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
        logic [SRAM_BW-1:0] wmask;
    } sram_cmd_t;

    localparam sram_cmd_t SRAM_CMD_IDLE = '{
        csb:   1'b1,
        web:   1'b1,
        addr:  '0,
        wdata: '0,
        wmask: '0
    };

    // A byte lane is written when any bit of the requester's mask in that lane is set.
    function automatic logic [SRAM_BW-1:0] wmask_bits_to_bytes(input logic [SRAM_DW-1:0] bits);
        logic [SRAM_BW-1:0] bytes;
        bytes = '0;
        for (int unsigned b = 0; b < SRAM_BW; b++) begin
            bytes[b] = |bits[8*b +: 8];
        end
        return bytes;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from ptr_q,
// pointer advances past the winner on every granted cycle.
module sram_rr_arbiter #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   winner,
    output logic              valid
);

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] ptr_d;

    // First pass covers requesters at or above the pointer; the second pass
    // only fires when none were found there, which yields the wrap-around.
    always_comb begin
        gnt    = '0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!valid && req[j] && (j >= 32'(ptr_q))) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                winner = IdxW'(j);
            end
        end
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                winner = IdxW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (valid) begin
            ptr_d = (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one negedge-launched single-port SRAM macro between NumReq req/gnt
// requesters with round-robin arbitration and a one-cycle read return.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    // The command struct is sized from the package, so AW/DW must match it.
    parameter int unsigned AW     = SRAM_AW,
    parameter int unsigned DW     = SRAM_DW
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumReq-1:0]          req_i,
    input  logic [NumReq-1:0]          we_i,
    input  logic [NumReq-1:0][AW-1:0]  addr_i,
    input  logic [NumReq-1:0][DW-1:0]  wdata_i,
    input  logic [NumReq-1:0][DW-1:0]  wmask_i,
    output logic [NumReq-1:0]          gnt_o,
    output logic [NumReq-1:0]          rvalid_o,
    output logic [DW-1:0]              rdata_o,
    output logic                       csb_o,
    output logic                       web_o,
    output logic [AW-1:0]              addr_o,
    output logic [DW-1:0]              wdata_o,
    output logic [DW/8-1:0]            wmask_o,
    input  logic [DW-1:0]              rdata_i
);

    localparam int unsigned IdxW = $clog2(NumReq);

    logic [IdxW-1:0] winner;
    logic            granted;
    sram_cmd_t       cmd_d;
    sram_cmd_t       cmd_q;
    logic            rd_vld_q;
    logic [IdxW-1:0] rd_idx_q;

    sram_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arbiter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req_i),
        .gnt    (gnt_o),
        .winner (winner),
        .valid  (granted)
    );

    // Idle cycles deselect the macro but keep the data-side pins steady.
    always_comb begin
        cmd_d     = cmd_q;
        cmd_d.csb = 1'b1;
        cmd_d.web = 1'b1;
        if (granted) begin
            cmd_d.csb   = 1'b0;
            cmd_d.web   = ~we_i[winner];
            cmd_d.addr  = addr_i[winner];
            cmd_d.wdata = wdata_i[winner];
            cmd_d.wmask = wmask_bits_to_bytes(wmask_i[winner]);
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= SRAM_CMD_IDLE;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rd_vld_q <= granted & ~we_i[winner];
            rd_idx_q <= winner;
        end
    end

    always_comb begin
        rvalid_o = '0;
        if (rd_vld_q) begin
            rvalid_o[rd_idx_q] = 1'b1;
        end
    end

    assign rdata_o = rdata_i;
    assign csb_o   = cmd_q.csb;
    assign web_o   = cmd_q.web;
    assign addr_o  = cmd_q.addr;
    assign wdata_o = cmd_q.wdata;
    assign wmask_o = cmd_q.wmask;

endmodule
